// File: rtl/mips_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_wb_pkg
//  Description : Shared widths, the $0 index and the writeback queue entry
//                type used by regfile_writeback and wb_queue.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // "reg" is a keyword, so the destination index field is named rd.
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic              ready;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : wb_queue
//  Description : In-order circular buffer of writeback entries with push at
//                the tail, pop at the head and an in-place fill of the oldest
//                not-ready entry. Pointers carry one extra wrap bit.
//  Revision    : 1.0  initial release
//  Ports       : clk, reset      clock, synchronous active-high reset
//                i_push/_entry   append entry at tail (caller checks o_full)
//                i_fill/_data    complete oldest not-ready entry
//                i_pop           retire head (caller checks head ready)
//                o_full          DEPTH entries held
//                o_pending       at least one not-ready entry queued
//                o_head          entry at the head slot
//                o_age_*         entries in age order, index 0 = head
//  Config      : REGFILE_WB_FORWARD_EN exposes per-entry ready/data.
// ============================================================================
module wb_queue
    import mips_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  wb_entry_t             i_push_entry,
    input  logic                  i_fill,
    input  logic [DATA_W-1:0]     i_fill_data,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_pending,
    output wb_entry_t             o_head,
    output logic [DEPTH-1:0]      o_age_valid,
`ifdef REGFILE_WB_FORWARD_EN
    output logic [DEPTH-1:0]      o_age_ready,
    output logic [DATA_W-1:0]     o_age_data [DEPTH],
`endif
    output logic [REG_W-1:0]      o_age_rd [DEPTH]
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;

    wb_entry_t            r_mem_q [DEPTH];
    wb_entry_t            w_mem_d [DEPTH];
    logic [c_PTR_W-1:0]   r_head_q, w_head_d;
    logic [c_PTR_W-1:0]   r_tail_q, w_tail_d;
    logic [c_PTR_W-1:0]   w_count;
    logic                 w_fill_found;
    logic [c_IDX_W-1:0]   w_fill_off;
    logic [c_IDX_W-1:0]   w_fill_slot;

    assign w_count = r_tail_q - r_head_q;
    assign o_full  = (w_count == c_PTR_W'(DEPTH));
    assign o_head  = r_mem_q[r_head_q[c_IDX_W-1:0]];

    // Age-ordered view: slot index wraps naturally because DEPTH is 2^n.
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        logic [c_IDX_W-1:0] w_slot;
        assign w_slot         = r_head_q[c_IDX_W-1:0] + c_IDX_W'(k);
        assign o_age_valid[k] = (c_PTR_W'(k) < w_count);
        assign o_age_rd[k]    = r_mem_q[w_slot].rd;
`ifdef REGFILE_WB_FORWARD_EN
        assign o_age_ready[k] = r_mem_q[w_slot].ready;
        assign o_age_data[k]  = r_mem_q[w_slot].data;
`endif
    end

    // Fill pointer: oldest queued entry still waiting for load data.
    // Scanning youngest to oldest leaves the oldest match in w_fill_off.
    always_comb begin
        w_fill_found = 1'b0;
        w_fill_off   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (o_age_valid[k] && !r_mem_q[r_head_q[c_IDX_W-1:0] + c_IDX_W'(k)].ready) begin
                w_fill_found = 1'b1;
                w_fill_off   = c_IDX_W'(k);
            end
        end
    end

    assign w_fill_slot = r_head_q[c_IDX_W-1:0] + w_fill_off;
    assign o_pending   = w_fill_found;

    // Push slot (tail), fill slot (not ready) and pop slot (ready head)
    // are always distinct, so the three updates never collide.
    always_comb begin
        w_mem_d  = r_mem_q;
        w_head_d = r_head_q;
        w_tail_d = r_tail_q;
        if (i_push) begin
            w_mem_d[r_tail_q[c_IDX_W-1:0]] = i_push_entry;
            w_tail_d = r_tail_q + c_PTR_W'(1);
        end
        if (i_fill && w_fill_found) begin
            w_mem_d[w_fill_slot].data  = i_fill_data;
            w_mem_d[w_fill_slot].ready = 1'b1;
        end
        if (i_pop) begin
            w_head_d = r_head_q + c_PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_q <= '0;
            r_tail_q <= '0;
        end else begin
            r_head_q <= w_head_d;
            r_tail_q <= w_tail_d;
        end
    end

    // Storage needs no reset: pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback
//  Description : In-order writeback sequencer feeding the single write port
//                of the 32x32 register file. Queues ALU results and load
//                reservations, waits for load data, guards $0 and publishes
//                a busy scoreboard.
//  Revision    : 1.0  initial release
//  Ports       : clk, reset                 clock, synchronous active-high reset
//                alu_valid/alu_reg/alu_data ALU writeback request
//                ld_issue/ld_reg            load slot reservation
//                ld_valid/ld_data           in-order load data return
//                full, err                  queue full, sticky protocol error
//                RegWrite/WriteReg/WriteData register file write port
//                busy_mask                  registers with a queued write
//  Config      : REGFILE_WB_FORWARD_EN adds fwd_reg_x / fwd_hit_x /
//                fwd_data_x (x = a, b) combinational forwarding lookups.
// ============================================================================
module regfile_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = mips_wb_pkg::DATA_W,
    parameter int REG_W  = mips_wb_pkg::REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_issue,
    input  logic [REG_W-1:0]  ld_reg,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
`ifdef REGFILE_WB_FORWARD_EN
    input  logic [REG_W-1:0]  fwd_reg_a,
    input  logic [REG_W-1:0]  fwd_reg_b,
    output logic              fwd_hit_a,
    output logic              fwd_hit_b,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic [DATA_W-1:0] fwd_data_b,
`endif
    output logic              full,
    output logic              err,
    output logic              RegWrite,
    output logic [REG_W-1:0]  WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic [31:0]       busy_mask
);

    import mips_wb_pkg::*;

    logic              w_full, w_pending;
    logic              w_push_req, w_push, w_fill, w_pop;
    wb_entry_t         w_push_entry, w_head;
    logic [DEPTH-1:0]  w_age_valid;
    logic [REG_W-1:0]  w_age_rd [DEPTH];
    logic              r_err_q, w_err_d;
    logic [31:0]       w_busy;
`ifdef REGFILE_WB_FORWARD_EN
    logic [DEPTH-1:0]  w_age_ready;
    logic [DATA_W-1:0] w_age_data [DEPTH];
`endif

    // A load wins over a simultaneous ALU request; $0 targets are accepted
    // but never occupy a slot.
    always_comb begin
        w_push_entry = '0;
        if (ld_issue) begin
            w_push_entry.rd = ld_reg;
            w_push_req      = (ld_reg != REG_ZERO);
        end else begin
            w_push_entry.rd    = alu_reg;
            w_push_entry.data  = alu_data;
            w_push_entry.ready = 1'b1;
            w_push_req         = alu_valid && (alu_reg != REG_ZERO);
        end
        // Full is judged before this cycle's pop, so a push is dropped
        // even when the head retires on the same edge.
        w_push  = w_push_req && !w_full;
        w_fill  = ld_valid && w_pending;
        w_err_d = r_err_q
                | (alu_valid && ld_issue)
                | (w_push_req && w_full)
                | (ld_valid && !w_pending);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_q <= 1'b0;
        end else begin
            r_err_q <= w_err_d;
        end
    end

    wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_fill       (w_fill),
        .i_fill_data  (ld_data),
        .i_pop        (w_pop),
        .o_full       (w_full),
        .o_pending    (w_pending),
        .o_head       (w_head),
        .o_age_valid  (w_age_valid),
`ifdef REGFILE_WB_FORWARD_EN
        .o_age_ready  (w_age_ready),
        .o_age_data   (w_age_data),
`endif
        .o_age_rd     (w_age_rd)
    );

    // The register file captures the head on the same edge it pops.
    assign w_pop     = w_age_valid[0] && w_head.ready;
    assign RegWrite  = w_pop;
    assign WriteReg  = w_pop ? w_head.rd   : '0;
    assign WriteData = w_pop ? w_head.data : '0;
    assign full      = w_full;
    assign err       = r_err_q;

    always_comb begin
        w_busy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_age_valid[k]) begin
                w_busy[w_age_rd[k]] = 1'b1;
            end
        end
        w_busy[0] = 1'b0;
    end

    assign busy_mask = w_busy;

`ifdef REGFILE_WB_FORWARD_EN
    // Oldest-to-youngest scan: the last match (youngest) sets the result.
    always_comb begin
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_age_valid[k] && (w_age_rd[k] == fwd_reg_a) && (fwd_reg_a != REG_ZERO)) begin
                fwd_hit_a  = w_age_ready[k];
                fwd_data_a = w_age_ready[k] ? w_age_data[k] : '0;
            end
            if (w_age_valid[k] && (w_age_rd[k] == fwd_reg_b) && (fwd_reg_b != REG_ZERO)) begin
                fwd_hit_b  = w_age_ready[k];
                fwd_data_b = w_age_ready[k] ? w_age_data[k] : '0;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_writeback
//  Description : Self-checking bench for regfile_writeback: directed cases
//                plus randomized traffic against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_writeback;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_reg;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        full, err, RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] busy_mask;
`ifdef REGFILE_WB_FORWARD_EN
    logic [4:0]  fwd_reg_a, fwd_reg_b;
    logic        fwd_hit_a, fwd_hit_b;
    logic [31:0] fwd_data_a, fwd_data_b;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    regfile_writeback #(.DEPTH(DEPTH), .DATA_W(32), .REG_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .ld_issue  (ld_issue),
        .ld_reg    (ld_reg),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
`ifdef REGFILE_WB_FORWARD_EN
        .fwd_reg_a (fwd_reg_a),
        .fwd_reg_b (fwd_reg_b),
        .fwd_hit_a (fwd_hit_a),
        .fwd_hit_b (fwd_hit_b),
        .fwd_data_a(fwd_data_a),
        .fwd_data_b(fwd_data_b),
`endif
        .full      (full),
        .err       (err),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .busy_mask (busy_mask)
    );

    always #5 clk = ~clk;

    // Reference model: a list of pending writes in program order.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          ready;
    } m_ent_t;

    m_ent_t mq[$];
    bit     m_err;

    function automatic void model_step();
        bit     was_full;
        bit     head_retires;
        int     fi;
        m_ent_t e;
        if (reset) begin
            mq.delete();
            m_err = 1'b0;
            return;
        end
        was_full     = (mq.size() == DEPTH);
        head_retires = (mq.size() > 0) && mq[0].ready;
        fi = -1;
        foreach (mq[i]) if (fi < 0 && !mq[i].ready) fi = i;
        if (ld_valid) begin
            if (fi < 0) m_err = 1'b1;
            else begin
                e = mq[fi]; e.data = ld_data; e.ready = 1'b1; mq[fi] = e;
            end
        end
        if (head_retires) void'(mq.pop_front());
        if (alu_valid && ld_issue) m_err = 1'b1;
        if (ld_issue) begin
            if (ld_reg != 0) begin
                if (was_full) m_err = 1'b1;
                else mq.push_back('{ld_reg, 32'h0, 1'b0});
            end
        end else if (alu_valid && alu_reg != 0) begin
            if (was_full) m_err = 1'b1;
            else mq.push_back('{alu_reg, alu_data, 1'b1});
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        reset = 0; alu_valid = 0; alu_reg = 0; alu_data = 0;
        ld_issue = 0; ld_reg = 0; ld_valid = 0; ld_data = 0;
    endtask

    task automatic do_reset();
        idle(); reset = 1; cycle(); cycle(); idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1; alu_valid = 1; alu_reg = 5; alu_data = 32'h55; ld_valid = 1; ld_data = 32'h77;
        cycle();
        idle();
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", RegWrite); end
        total++; if (WriteReg !== 5'd0) begin bad++; $display("FAIL reset_wreg got=%0d exp=0", WriteReg); end
        total++; if (WriteData !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", WriteData); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
    endtask

    task automatic test_alu_write();
        do_reset();
        alu_valid = 1; alu_reg = 8; alu_data = 32'hDEADBEEF;
        cycle();
        idle();
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL alu_we got=%b exp=1", RegWrite); end
        total++; if (WriteReg !== 5'd8) begin bad++; $display("FAIL alu_wreg got=%0d exp=8", WriteReg); end
        total++; if (WriteData !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_wdata got=%h exp=deadbeef", WriteData); end
        total++; if (busy_mask !== 32'h100) begin bad++; $display("FAIL alu_busy got=%h exp=100", busy_mask); end
        cycle();
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL alu_after_we got=%b exp=0", RegWrite); end
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL alu_after_busy got=%h exp=0", busy_mask); end
    endtask

    task automatic test_reg_zero();
        do_reset();
        alu_valid = 1; alu_reg = 0; alu_data = 32'hFFFFFFFF;
        cycle();
        idle();
        for (int i = 0; i < 2; i++) begin
            total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL r0_we cyc=%0d got=%b exp=0", i, RegWrite); end
            total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL r0_busy cyc=%0d got=%h exp=0", i, busy_mask); end
            cycle();
        end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL r0_err got=%b exp=0", err); end
    endtask

    task automatic test_load_order();
        logic [4:0]  er [3];
        logic [31:0] ed [3];
        er = '{5'd9, 5'd10, 5'd10};
        ed = '{32'h1234, 32'h1, 32'h2};
        do_reset();
        ld_issue = 1; ld_reg = 9; cycle(); idle();
        alu_valid = 1; alu_reg = 10; alu_data = 1; cycle();
        alu_data = 2; cycle(); idle();
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL ld_blocked_we got=%b exp=0", RegWrite); end
        total++; if (busy_mask !== 32'h600) begin bad++; $display("FAIL ld_busy got=%h exp=600", busy_mask); end
        ld_valid = 1; ld_data = 32'h1234;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL ld_fillcyc_we got=%b exp=0", RegWrite); end
        cycle(); idle();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (RegWrite !== 1'b1 || WriteReg !== er[i] || WriteData !== ed[i]) begin
                bad++;
                $display("FAIL ld_order idx=%0d got=(%b,%0d,%h) exp=(1,%0d,%h)", i, RegWrite, WriteReg, WriteData, er[i], ed[i]);
            end
            cycle();
        end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL ld_done_we got=%b exp=0", RegWrite); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            ld_issue = 1; ld_reg = 5'(i); cycle();
        end
        idle();
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full_set got=%b exp=1", full); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL full_err0 got=%b exp=0", err); end
        ld_issue = 1; ld_reg = 5; cycle(); idle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL full_drop_err got=%b exp=1", err); end
        total++; if (busy_mask !== 32'h1E) begin bad++; $display("FAIL full_busy got=%h exp=1e", busy_mask); end
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_data = 32'h100 + 32'(i);
            if (i > 0) begin
                total++;
                if (RegWrite !== 1'b1 || WriteReg !== 5'(i) || WriteData !== 32'h100 + 32'(i - 1)) begin
                    bad++;
                    $display("FAIL full_drain idx=%0d got=(%b,%0d,%h) exp=(1,%0d,%h)", i, RegWrite, WriteReg, WriteData, i, 32'h100 + 32'(i - 1));
                end
            end
            cycle();
        end
        idle();
        total++; if (RegWrite !== 1'b1 || WriteReg !== 5'd4 || WriteData !== 32'h103) begin
            bad++; $display("FAIL full_last got=(%b,%0d,%h) exp=(1,4,103)", RegWrite, WriteReg, WriteData); end
        cycle();
        total++; if (full !== 1'b0) begin bad++; $display("FAIL full_clear got=%b exp=0", full); end
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL full_busy_end got=%h exp=0", busy_mask); end
    endtask

    task automatic test_errors();
        do_reset();
        ld_valid = 1; ld_data = 32'hAB; cycle(); idle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL stray_fill_err got=%b exp=1", err); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL stray_fill_we got=%b exp=0", RegWrite); end
        do_reset();
        alu_valid = 1; alu_reg = 7; alu_data = 32'h55; ld_issue = 1; ld_reg = 6;
        cycle(); idle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL both_err got=%b exp=1", err); end
        total++; if (busy_mask !== 32'h40) begin bad++; $display("FAIL both_busy got=%h exp=40", busy_mask); end
        ld_valid = 1; ld_data = 32'h66; cycle(); idle();
        total++; if (RegWrite !== 1'b1 || WriteReg !== 5'd6 || WriteData !== 32'h66) begin
            bad++; $display("FAIL both_write got=(%b,%0d,%h) exp=(1,6,66)", RegWrite, WriteReg, WriteData); end
        cycle();
        total++; if (RegWrite !== 1'b0 || busy_mask !== 32'h0) begin
            bad++; $display("FAIL both_alu_dropped got=(%b,%h) exp=(0,0)", RegWrite, busy_mask); end
        // Mid-operation reset with data returning in the reset cycle.
        ld_issue = 1; ld_reg = 13; cycle();
        idle(); alu_valid = 1; alu_reg = 14; alu_data = 32'h44; cycle();
        idle(); reset = 1; ld_valid = 1; ld_data = 32'h99; alu_valid = 1; alu_reg = 15;
        cycle(); idle();
        total++; if ({RegWrite, full, err} !== 3'b000 || WriteReg !== 5'd0 || WriteData !== 32'd0 || busy_mask !== 32'd0) begin
            bad++; $display("FAIL midreset got=(we%b full%b err%b %0d %h %h) exp=all 0", RegWrite, full, err, WriteReg, WriteData, busy_mask); end
        ld_valid = 1; ld_data = 32'h12; cycle(); idle();
        total++; if (err !== 1'b1 || RegWrite !== 1'b0) begin
            bad++; $display("FAIL discarded_load got=(err%b we%b) exp=(1,0)", err, RegWrite); end
    endtask

`ifdef REGFILE_WB_FORWARD_EN
    task automatic test_forward();
        do_reset();
        fwd_reg_a = 8; fwd_reg_b = 3;
        ld_issue = 1; ld_reg = 3; cycle(); idle();
        alu_valid = 1; alu_reg = 8; alu_data = 32'hA; cycle(); idle();
        ld_issue = 1; ld_reg = 8; cycle(); idle();
        total++; if (fwd_hit_a !== 1'b0 || fwd_data_a !== 32'h0) begin
            bad++; $display("FAIL fwd_pending got=(%b,%h) exp=(0,0)", fwd_hit_a, fwd_data_a); end
        total++; if (fwd_hit_b !== 1'b0) begin bad++; $display("FAIL fwd_b_pending got=%b exp=0", fwd_hit_b); end
        ld_valid = 1; ld_data = 32'h33; cycle(); idle();
        total++; if (fwd_hit_a !== 1'b0) begin bad++; $display("FAIL fwd_after_first got=%b exp=0", fwd_hit_a); end
        total++; if (fwd_hit_b !== 1'b1 || fwd_data_b !== 32'h33) begin
            bad++; $display("FAIL fwd_b_hit got=(%b,%h) exp=(1,33)", fwd_hit_b, fwd_data_b); end
        ld_valid = 1; ld_data = 32'hB; cycle(); idle();
        total++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 32'hB) begin
            bad++; $display("FAIL fwd_hit got=(%b,%h) exp=(1,b)", fwd_hit_a, fwd_data_a); end
    endtask
`endif

    task automatic test_random();
        bit          exp_we;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        logic [31:0] exp_busy;
        int          r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            exp_we   = (mq.size() > 0) && mq[0].ready;
            exp_reg  = exp_we ? mq[0].rd : 5'd0;
            exp_data = exp_we ? mq[0].data : 32'd0;
            exp_busy = '0;
            foreach (mq[i]) exp_busy[mq[i].rd] = 1'b1;
            exp_busy[0] = 1'b0;
            total++; if (RegWrite !== exp_we) begin bad++; $display("FAIL rand_we cyc=%0d got=%b exp=%b", n, RegWrite, exp_we); end
            total++; if (WriteReg !== exp_reg) begin bad++; $display("FAIL rand_wreg cyc=%0d got=%0d exp=%0d", n, WriteReg, exp_reg); end
            total++; if (WriteData !== exp_data) begin bad++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", n, WriteData, exp_data); end
            total++; if (full !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", n, full, mq.size() == DEPTH); end
            total++; if (err !== m_err) begin bad++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", n, err, m_err); end
            total++; if (busy_mask !== exp_busy) begin bad++; $display("FAIL rand_busy cyc=%0d got=%h exp=%h", n, busy_mask, exp_busy); end
            r         = int'($urandom_range(99));
            reset     = ($urandom_range(99) < 2);
            alu_valid = (r < 45);
            ld_issue  = (r >= 45 && r < 70) || (r < 3);
            alu_reg   = 5'($urandom_range(31));
            alu_data  = $urandom;
            ld_reg    = 5'($urandom_range(31, 1));
            ld_valid  = ($urandom_range(99) < 35);
            ld_data   = $urandom;
            cycle();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_write();
        test_reg_zero();
        test_load_order();
        test_full();
        test_errors();
`ifdef REGFILE_WB_FORWARD_EN
        test_forward();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
